// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: ALU result, control, architectural flags, forwarding and retire count.
// Latency 1 cycle; stall holds everything, flush or an empty EX slot inserts a bubble.
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_zero,
  input  logic              alu_gt,
  input  logic              alu_overflow,
  input  logic              alu_negative,
  input  logic              set_flags,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_to_reg,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic [REG_AW-1:0] out_rd_addr,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_mem_to_reg,
  output logic [4:0]        flags,
  output logic              fwd_en,
  output logic [DATA_W-1:0] fwd_value,
  output logic [CNT_W-1:0]  exec_count
);

  logic              r_valid;
  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] r_store_data;
  logic [REG_AW-1:0] r_rd_addr;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_mem_to_reg;
  logic [4:0]        r_flags;
  logic [CNT_W-1:0]  r_exec_count;

  logic w_accept;
  logic w_bubble;

  // Flush beats stall: a squashed instruction must never survive a held cycle.
  assign w_accept = ~stall & ~flush & in_valid;
  assign w_bubble = flush | (~stall & ~in_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_result     <= '0;
      r_store_data <= '0;
      r_rd_addr    <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_flags      <= '0;
      r_exec_count <= '0;
    end else if (w_accept) begin
      r_valid      <= 1'b1;
      r_result     <= alu_result;
      r_store_data <= store_data;
      r_rd_addr    <= rd_addr;
      r_reg_write  <= reg_write;
      r_mem_read   <= mem_read;
      r_mem_write  <= mem_write;
      r_mem_to_reg <= mem_to_reg;
      r_exec_count <= r_exec_count + 1'b1;
      if (set_flags) begin
        r_flags <= {alu_negative, alu_zero, alu_carry, alu_overflow, alu_gt};
      end
    end else if (w_bubble) begin
      // Data fields keep their last values; only validity and control are squashed.
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end
  end

  assign out_valid      = r_valid;
  assign out_result     = r_result;
  assign out_store_data = r_store_data;
  assign out_rd_addr    = r_rd_addr;
  assign out_reg_write  = r_reg_write;
  assign out_mem_read   = r_mem_read;
  assign out_mem_write  = r_mem_write;
  assign out_mem_to_reg = r_mem_to_reg;
  assign flags          = r_flags;
  assign exec_count     = r_exec_count;

  // Loads cannot forward from here and r0 is never a real producer.
  assign fwd_en    = r_valid & r_reg_write & ~r_mem_read & (r_rd_addr != '0);
  assign fwd_value = r_result;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboarded bench for ex_mem_stage: directed scenarios followed by randomized traffic.
module tb_ex_mem_stage;
  localparam int DATA_W = 32;
  localparam int REG_AW = 4;
  localparam int CNT_W  = 4;
  localparam int VW     = 1 + DATA_W + DATA_W + REG_AW + 4 + 5 + 1 + DATA_W + CNT_W;

  logic              clk = 1'b0;
  logic              rst, stall, flush, in_valid;
  logic [DATA_W-1:0] alu_result, store_data;
  logic              alu_carry, alu_zero, alu_gt, alu_overflow, alu_negative, set_flags;
  logic [REG_AW-1:0] rd_addr;
  logic              reg_write, mem_read, mem_write, mem_to_reg;
  logic              out_valid;
  logic [DATA_W-1:0] out_result, out_store_data, fwd_value;
  logic [REG_AW-1:0] out_rd_addr;
  logic              out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg, fwd_en;
  logic [4:0]        flags;
  logic [CNT_W-1:0]  exec_count;

  ex_mem_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_gt(alu_gt),
    .alu_overflow(alu_overflow), .alu_negative(alu_negative), .set_flags(set_flags),
    .store_data(store_data), .rd_addr(rd_addr), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .out_valid(out_valid),
    .out_result(out_result), .out_store_data(out_store_data), .out_rd_addr(out_rd_addr),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_mem_to_reg(out_mem_to_reg), .flags(flags), .fwd_en(fwd_en), .fwd_value(fwd_value),
    .exec_count(exec_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              rst, stall, flush, vld;
    logic [DATA_W-1:0] res;
    logic              c, z, gt, v, n, setf;
    logic [DATA_W-1:0] sdat;
    logic [REG_AW-1:0] rd;
    logic              rw, mr, mw, m2r;
  } stim_t;

  typedef struct {
    logic [VW-1:0] v;
    int            idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   n_push = 0;

  // Architectural view of the stage, updated by the rules directly
  bit          m_valid, m_rw, m_mr, m_mw, m_m2r;
  int unsigned m_res, m_sdat, m_rd, m_cnt;
  bit [4:0]    m_flags;

  task automatic drive(input stim_t s);
    bit [VW-1:0] e;
    bit          fe;
    @(negedge clk);
    rst = s.rst; stall = s.stall; flush = s.flush; in_valid = s.vld;
    alu_result = s.res; alu_carry = s.c; alu_zero = s.z; alu_gt = s.gt;
    alu_overflow = s.v; alu_negative = s.n; set_flags = s.setf;
    store_data = s.sdat; rd_addr = s.rd; reg_write = s.rw; mem_read = s.mr;
    mem_write = s.mw; mem_to_reg = s.m2r;
    if (s.rst) begin
      m_valid = 0; m_res = 0; m_sdat = 0; m_rd = 0;
      m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0; m_flags = 0; m_cnt = 0;
    end else if (s.flush || (!s.stall && !s.vld)) begin
      m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0;
    end else if (!s.stall) begin
      m_valid = 1; m_res = s.res; m_sdat = s.sdat; m_rd = s.rd;
      m_rw = s.rw; m_mr = s.mr; m_mw = s.mw; m_m2r = s.m2r;
      m_cnt = (m_cnt + 1) % 16;
      if (s.setf) m_flags = {s.n, s.z, s.c, s.v, s.gt};
    end
    fe = m_valid && m_rw && !m_mr && (m_rd != 0);
    e = {m_valid, m_res[DATA_W-1:0], m_sdat[DATA_W-1:0], m_rd[REG_AW-1:0],
         m_rw, m_mr, m_mw, m_m2r, m_flags, fe, m_res[DATA_W-1:0], m_cnt[CNT_W-1:0]};
    exp_q.push_back('{v: e, idx: n_push});
    n_push++;
  endtask

  function automatic stim_t acc(input int unsigned res, input int unsigned rd, input bit rw);
    stim_t s = '0;
    s.vld = 1; s.res = res; s.rd = rd[REG_AW-1:0]; s.rw = rw; s.sdat = res ^ 32'h5A5A_5A5A;
    return s;
  endfunction

  // Monitor: the stage presents a result every cycle, so each edge retires one expectation
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      exp_t        x;
      logic [VW-1:0] act;
      x   = exp_q.pop_front();
      act = {out_valid, out_result, out_store_data, out_rd_addr, out_reg_write,
             out_mem_read, out_mem_write, out_mem_to_reg, flags, fwd_en, fwd_value, exec_count};
      n_vec++;
      if (act !== x.v) begin
        n_fail++;
        $display("FAIL vec%0d outputs got %h expected %h", x.idx, act, x.v);
      end
    end
  end

  initial begin
    stim_t s;
    int    guard;
    // reset for two cycles with live stimulus, then idle
    s = acc(32'hFFFF_FFFF, 9, 1); s.rst = 1; s.stall = 1; s.setf = 1; s.n = 1;
    drive(s); drive(s);
    s = '0;
    repeat (3) drive(s);
    // capture with flags {N,Z,C,V,GT} = 00101
    s = acc(32'h5, 3, 1); s.setf = 1; s.c = 1; s.gt = 1; drive(s);
    s = acc(32'h9, 4, 1); s.z = 1; drive(s);
    // stall holds result, flags and count
    s = acc(32'hDEAD_BEEF, 5, 1); drive(s);
    s = acc(32'h1234, 6, 1); s.stall = 1; s.setf = 1; s.n = 1; s.v = 1;
    repeat (3) drive(s);
    s.stall = 0; drive(s);
    // stall + flush: bubble, no count or flag change
    s = acc(32'hCAFE, 8, 0); s.mw = 1; s.stall = 1; s.flush = 1; s.setf = 1; s.z = 1; drive(s);
    // forwarding suppression cases
    s = acc(32'h11, 0, 1); drive(s);
    s = acc(32'h22, 7, 1); s.mr = 1; s.m2r = 1; drive(s);
    s = acc(32'h33, 7, 1); drive(s);
    // counter wrap over 17 accepts
    s = '0; s.rst = 1; drive(s);
    for (int i = 0; i < 17; i++) begin
      s = acc(i, i % 16, i[0]); drive(s);
    end
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      s = '0;
      s.rst   = ($urandom_range(0, 99) < 2);
      s.stall = ($urandom_range(0, 99) < 25);
      s.flush = ($urandom_range(0, 99) < 15);
      s.vld   = ($urandom_range(0, 99) < 75);
      s.res   = $urandom; s.sdat = $urandom;
      s.c = $urandom_range(0, 1); s.z = $urandom_range(0, 1); s.gt = $urandom_range(0, 1);
      s.v = $urandom_range(0, 1); s.n = $urandom_range(0, 1); s.setf = $urandom_range(0, 1);
      s.rd  = $urandom_range(0, 15);
      s.rw  = $urandom_range(0, 1); s.mr = $urandom_range(0, 1);
      s.mw  = $urandom_range(0, 1); s.m2r = $urandom_range(0, 1);
      drive(s);
    end
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
